// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request, two-entry registered
// buffer (output register + skid) feeding decode, with redirect and misalignment fault.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fault
);

    // state    | meaning
    // FETCH    | no request outstanding; issues at pc when the skid is empty
    // WAIT     | request outstanding, data will be kept
    // DISCARD  | request outstanding, data will be dropped
    // HALT     | misaligned redirect seen; idle until reset
    typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_DISCARD, ST_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dis_addr_q, dis_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        fault_q, fault_d;

    logic acked, pending, redir_ok, misaligned, consume, take;

    assign acked      = imem_req & imem_ack;
    assign pending    = imem_req & ~imem_ack;
    assign redir_ok   = redirect & ~fault_q;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign consume    = out_valid_q & ~stall;
    assign take       = acked & ((state_q == ST_FETCH) | (state_q == ST_WAIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            dis_addr_q   <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'd0;
            out_pc_q     <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            dis_addr_q   <= dis_addr_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH, ST_WAIT: begin
                if (redir_ok) begin
                    if (pending)         state_d = ST_DISCARD;
                    else if (misaligned) state_d = ST_HALT;
                    else                 state_d = ST_FETCH;
                end else if (acked) begin
                    state_d = ST_FETCH;
                end else if (imem_req) begin
                    state_d = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                // A fault raised while discarding parks in HALT once the old request retires
                if (imem_ack)
                    state_d = (fault_q | (redir_ok & misaligned)) ? ST_HALT : ST_FETCH;
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            ST_FETCH:   imem_req = ~skid_valid_q;
            ST_WAIT:    imem_req = 1'b1;
            ST_DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = dis_addr_q;
            end
            default:    imem_req = 1'b0;
        endcase
        if (!reset)
            imem_req = 1'b0;
    end

    always_comb begin
        pc_d         = pc_q;
        dis_addr_d   = dis_addr_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        fault_d      = fault_q;
        if (redir_ok) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            if (misaligned) fault_d = 1'b1;
            else            pc_d    = redirect_pc;
            if (pending)    dis_addr_d = imem_addr;
        end else begin
            if (take)
                pc_d = pc_q + 32'd4;
            if (consume || !out_valid_q) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = take;
                    skid_instr_d = imem_rdata;
                    skid_pc_d    = imem_addr;
                end else if (take) begin
                    out_valid_d = 1'b1;
                    out_instr_d = imem_rdata;
                    out_pc_d    = imem_addr;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (take) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = imem_addr;
            end
        end
    end

    assign instr       = out_instr_q;
    assign opcode      = out_instr_q[31:26];
    assign instr_pc    = out_pc_q;
    assign instr_valid = out_valid_q;
    assign fault       = fault_q;

endmodule
